// File: rtl/axis_tx_arbiter.sv
// -----------------------------------------------------------------------------
// axis_tx_arbiter
//
// Shares one AXI-Stream transmit path between NUM_REQ packet producers.
// A round-robin search picks one requester per packet. The packet is then
// streamed beat by beat until its last beat is accepted. A packet is never
// preempted, and requests are only looked at while the block is idle.
//
// Ports
//   ACLK, ARESETn     clock (rising edge) and synchronous active-low reset
//   req_i[NUM_REQ]    requester i has a packet pending
//   len_i             per-requester beat count, sampled at grant (0 -> 1 beat)
//   data_i            per-requester current beat, advanced by the requester
//                     after its pop_o
//   gnt_o             one-hot grant, held for the whole packet (registered)
//   pop_o             one-hot beat-accepted strobe (combinational)
//   TVALID/TREADY     stream handshake
//   TDATA             granted requester's data_i slice (combinational)
//   TLAST, TID        last-beat flag and granted index (registered)
//   TKEEP, TSTRB      all ones while TVALID, else zero
//   busy_o            high while a packet is being sent
//   pkt_cnt_o         completed packet count, wraps at 16 bits
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no packet in flight; round-robin search over req_i each cycle
// SEND  | streaming the granted packet; req_i is ignored
// -----------------------------------------------------------------------------
module axis_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,
  parameter int LEN_W   = 8,
  parameter int ID_W    = 7
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*LEN_W-1:0]  len_i,
  input  logic [NUM_REQ*DATA_W-1:0] data_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        pop_o,
  output logic                      TVALID,
  input  logic                      TREADY,
  output logic [DATA_W-1:0]         TDATA,
  output logic                      TLAST,
  output logic [ID_W-1:0]           TID,
  output logic [DATA_W/8-1:0]       TKEEP,
  output logic [DATA_W/8-1:0]       TSTRB,
  output logic                      busy_o,
  output logic [15:0]               pkt_cnt_o
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int KEEP_W = DATA_W / 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [LEN_W-1:0]   beats_left_q, beats_left_d;
  logic               tvalid_q, tvalid_d;
  logic               tlast_q, tlast_d;
  logic [15:0]        pkt_cnt_q, pkt_cnt_d;

  logic               found;
  logic [IDX_W-1:0]   sel;
  logic [LEN_W-1:0]   sel_len;
  logic               handshake;
  int                 cand;

  // First pending requester at or above rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!found && req_i[cand]) begin
        found = 1'b1;
        sel   = IDX_W'(cand);
      end
    end
  end

  assign sel_len   = len_i[int'(sel)*LEN_W +: LEN_W];
  assign handshake = tvalid_q && TREADY;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      idx_q        <= '0;
      rr_ptr_q     <= '0;
      beats_left_q <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      pkt_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      idx_q        <= idx_d;
      rr_ptr_q     <= rr_ptr_d;
      beats_left_q <= beats_left_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      pkt_cnt_q    <= pkt_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    idx_d        = idx_q;
    rr_ptr_d     = rr_ptr_q;
    beats_left_d = beats_left_q;
    tvalid_d     = tvalid_q;
    tlast_d      = tlast_q;
    pkt_cnt_d    = pkt_cnt_q;

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d      = SEND;
          gnt_d        = NUM_REQ'(1) << sel;
          idx_d        = sel;
          beats_left_d = (sel_len == '0) ? LEN_W'(1) : sel_len;
          tvalid_d     = 1'b1;
          tlast_d      = (sel_len <= LEN_W'(1));
        end
      end
      SEND: begin
        if (handshake) begin
          beats_left_d = beats_left_q - LEN_W'(1);
          if (beats_left_q == LEN_W'(1)) begin
            state_d   = IDLE;
            gnt_d     = '0;
            idx_d     = '0;
            tvalid_d  = 1'b0;
            tlast_d   = 1'b0;
            pkt_cnt_d = pkt_cnt_q + 16'd1;
            rr_ptr_d  = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
          end else begin
            // Register TLAST one beat ahead so it is valid with the final beat.
            tlast_d = (beats_left_q == LEN_W'(2));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign gnt_o     = gnt_q;
  assign TVALID    = tvalid_q;
  assign TLAST     = tlast_q;
  assign TID       = ID_W'(idx_q);
  assign busy_o    = (state_q == SEND);
  assign pkt_cnt_o = pkt_cnt_q;

  // idx_q is cleared whenever TVALID is low, so the mux cannot leak data.
  assign TDATA = tvalid_q ? data_i[int'(idx_q)*DATA_W +: DATA_W] : '0;
  assign TKEEP = {KEEP_W{tvalid_q}};
  assign TSTRB = {KEEP_W{tvalid_q}};
  assign pop_o = handshake ? gnt_q : '0;

endmodule

// File: tb/tb_axis_tx_arbiter.sv
module tb_axis_tx_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [3:0]  req_i;
  logic [31:0] len_i;
  logic [63:0] data_i;
  logic [3:0]  gnt_o;
  logic [3:0]  pop_o;
  logic        TVALID;
  logic        TREADY;
  logic [15:0] TDATA;
  logic        TLAST;
  logic [6:0]  TID;
  logic [1:0]  TKEEP;
  logic [1:0]  TSTRB;
  logic        busy_o;
  logic [15:0] pkt_cnt_o;

  int checks   = 0;
  int failures = 0;

  always #5 ACLK = ~ACLK;

  axis_tx_arbiter #(.NUM_REQ(4), .DATA_W(16), .LEN_W(8), .ID_W(7)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .req_i(req_i), .len_i(len_i),
    .data_i(data_i), .gnt_o(gnt_o), .pop_o(pop_o), .TVALID(TVALID),
    .TREADY(TREADY), .TDATA(TDATA), .TLAST(TLAST), .TID(TID),
    .TKEEP(TKEEP), .TSTRB(TSTRB), .busy_o(busy_o), .pkt_cnt_o(pkt_cnt_o)
  );

  // Requester model: requester i presents (i+1)*10000 - beats_popped.
  logic       clr;
  logic [15:0] beat_idx [4];

  initial for (int i = 0; i < 4; i++) beat_idx[i] = '0;

  always @(posedge ACLK) begin
    for (int i = 0; i < 4; i++) begin
      if (clr)           beat_idx[i] <= '0;
      else if (pop_o[i]) beat_idx[i] <= beat_idx[i] + 16'd1;
    end
  end

  always_comb begin
    data_i = '0;
    for (int i = 0; i < 4; i++)
      data_i[i*16 +: 16] = 16'((i + 1) * 10000) - beat_idx[i];
  end

  typedef struct {
    logic [3:0]  req;
    logic [31:0] len;
    logic        tready;
    logic        clr;
    logic [3:0]  gnt;
    logic        tvalid;
    logic        tlast;
    logic [6:0]  tid;
    logic [15:0] tdata;
    logic [3:0]  pop;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] rq, input logic [31:0] ln, input logic tr,
                     input logic cl, input logic [3:0] g, input logic tv,
                     input logic tl, input logic [6:0] id, input logic [15:0] td,
                     input logic [3:0] p, input logic [15:0] c);
    vec_t v;
    v.req = rq; v.len = ln; v.tready = tr; v.clr = cl; v.gnt = g; v.tvalid = tv;
    v.tlast = tl; v.tid = id; v.tdata = td; v.pop = p; v.cnt = c;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] g, input logic tv,
                           input logic tl, input logic [6:0] id, input logic [15:0] td,
                           input logic [3:0] p, input logic [15:0] c);
    chk({tag, " gnt"},    32'(gnt_o),     32'(g));
    chk({tag, " tvalid"}, 32'(TVALID),    32'(tv));
    chk({tag, " tlast"},  32'(TLAST),     32'(tl));
    chk({tag, " tid"},    32'(TID),       32'(id));
    chk({tag, " tdata"},  32'(TDATA),     32'(td));
    chk({tag, " pop"},    32'(pop_o),     32'(p));
    chk({tag, " pkt_cnt"},32'(pkt_cnt_o), 32'(c));
    chk({tag, " busy"},   32'(busy_o),    32'(tv));
    chk({tag, " tkeep"},  32'(TKEEP),     tv ? 32'd3 : 32'd0);
    chk({tag, " tstrb"},  32'(TSTRB),     tv ? 32'd3 : 32'd0);
  endtask

  task automatic next_cycle();
    @(posedge ACLK);
    #1;
  endtask

  task automatic drive(input logic [3:0] rq, input logic [31:0] ln, input logic tr,
                       input logic cl);
    req_i = rq; len_i = ln; TREADY = tr; clr = cl;
    #1;
  endtask

  localparam logic [31:0] L_RR = 32'h0101_0101;
  localparam logic [31:0] L3   = 32'h0000_0003;

  initial begin
    ARESETn = 1'b0; req_i = '0; len_i = '0; TREADY = 1'b1; clr = 1'b1;
    next_cycle();
    next_cycle();
    #1;
    check_all("reset", 4'd0, 0, 0, 7'd0, 16'd0, 4'd0, 16'd0);
    ARESETn = 1'b1;

    // Round robin from reset: TID 0,1,2,3,0 with one idle cycle between.
    add(4'hF, L_RR, 1, 0, 4'd0, 0, 0, 7'd0, 16'd0,     4'd0, 16'd0);
    add(4'hF, L_RR, 1, 0, 4'd1, 1, 1, 7'd0, 16'd10000, 4'd1, 16'd0);
    add(4'hF, L_RR, 1, 0, 4'd0, 0, 0, 7'd0, 16'd0,     4'd0, 16'd1);
    add(4'hF, L_RR, 1, 0, 4'd2, 1, 1, 7'd1, 16'd20000, 4'd2, 16'd1);
    add(4'hF, L_RR, 1, 0, 4'd0, 0, 0, 7'd0, 16'd0,     4'd0, 16'd2);
    add(4'hF, L_RR, 1, 0, 4'd4, 1, 1, 7'd2, 16'd30000, 4'd4, 16'd2);
    add(4'hF, L_RR, 1, 0, 4'd0, 0, 0, 7'd0, 16'd0,     4'd0, 16'd3);
    add(4'hF, L_RR, 1, 0, 4'd8, 1, 1, 7'd3, 16'd40000, 4'd8, 16'd3);
    add(4'hF, L_RR, 1, 0, 4'd0, 0, 0, 7'd0, 16'd0,     4'd0, 16'd4);
    add(4'h0, L_RR, 1, 0, 4'd1, 1, 1, 7'd0, 16'd9999,  4'd1, 16'd4);
    add(4'h0, L_RR, 1, 1, 4'd0, 0, 0, 7'd0, 16'd0,     4'd0, 16'd5);
    // Single requester, 3 beats, no backpressure (rr_ptr=1 wraps to 0).
    add(4'h1, L3, 1, 0, 4'd0, 0, 0, 7'd0, 16'd0,     4'd0, 16'd5);
    add(4'h1, L3, 1, 0, 4'd1, 1, 0, 7'd0, 16'd10000, 4'd1, 16'd5);
    add(4'h1, L3, 1, 0, 4'd1, 1, 0, 7'd0, 16'd9999,  4'd1, 16'd5);
    add(4'h0, L3, 1, 0, 4'd1, 1, 1, 7'd0, 16'd9998,  4'd1, 16'd5);
    add(4'h0, L3, 1, 1, 4'd0, 0, 0, 7'd0, 16'd0,     4'd0, 16'd6);
    // Backpressure on beat 2 for two cycles.
    add(4'h1, L3, 1, 0, 4'd0, 0, 0, 7'd0, 16'd0,     4'd0, 16'd6);
    add(4'h1, L3, 1, 0, 4'd1, 1, 0, 7'd0, 16'd10000, 4'd1, 16'd6);
    add(4'h1, L3, 0, 0, 4'd1, 1, 0, 7'd0, 16'd9999,  4'd0, 16'd6);
    add(4'h1, L3, 0, 0, 4'd1, 1, 0, 7'd0, 16'd9999,  4'd0, 16'd6);
    add(4'h1, L3, 1, 0, 4'd1, 1, 0, 7'd0, 16'd9999,  4'd1, 16'd6);
    add(4'h0, L3, 1, 0, 4'd1, 1, 1, 7'd0, 16'd9998,  4'd1, 16'd6);
    add(4'h0, L3, 1, 1, 4'd0, 0, 0, 7'd0, 16'd0,     4'd0, 16'd7);
    // Zero length on requester 2 is a single beat.
    add(4'h4, 32'd0, 1, 0, 4'd0, 0, 0, 7'd0, 16'd0,     4'd0, 16'd7);
    add(4'h0, 32'd0, 1, 0, 4'd4, 1, 1, 7'd2, 16'd30000, 4'd4, 16'd7);
    add(4'h0, 32'd0, 1, 1, 4'd0, 0, 0, 7'd0, 16'd0,     4'd0, 16'd8);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].req, vecs[i].len, vecs[i].tready, vecs[i].clr);
      check_all($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].tvalid, vecs[i].tlast,
                vecs[i].tid, vecs[i].tdata, vecs[i].pop, vecs[i].cnt);
      next_cycle();
    end

    // Non-preemption: req1 rises on beat 2 of a 4-beat req0 packet.
    drive(4'h1, 32'h4, 1, 0); check_all("np idle0", 4'd0, 0, 0, 7'd0, 16'd0, 4'd0, 16'd8);     next_cycle();
    drive(4'h1, 32'h4, 1, 0); check_all("np b1", 4'd1, 1, 0, 7'd0, 16'd10000, 4'd1, 16'd8);     next_cycle();
    drive(4'h3, 32'h4, 1, 0); check_all("np b2", 4'd1, 1, 0, 7'd0, 16'd9999, 4'd1, 16'd8);      next_cycle();
    drive(4'h3, 32'h4, 1, 0); check_all("np b3", 4'd1, 1, 0, 7'd0, 16'd9998, 4'd1, 16'd8);      next_cycle();
    drive(4'h3, 32'h4, 1, 0); check_all("np b4", 4'd1, 1, 1, 7'd0, 16'd9997, 4'd1, 16'd8);      next_cycle();
    drive(4'h3, 32'h4, 1, 0); check_all("np idle1", 4'd0, 0, 0, 7'd0, 16'd0, 4'd0, 16'd9);     next_cycle();
    drive(4'h0, 32'h4, 1, 0); check_all("np req1", 4'd2, 1, 1, 7'd1, 16'd20000, 4'd2, 16'd9);  next_cycle();
    drive(4'h0, 32'h4, 1, 1); check_all("np idle2", 4'd0, 0, 0, 7'd0, 16'd0, 4'd0, 16'd10);    next_cycle();

    // Reset during beat 2 of a 4-beat req3 packet.
    drive(4'h8, 32'h0400_0000, 1, 0); check_all("rst idle", 4'd0, 0, 0, 7'd0, 16'd0, 4'd0, 16'd10); next_cycle();
    drive(4'h8, 32'h0400_0000, 1, 0); check_all("rst b1", 4'd8, 1, 0, 7'd3, 16'd40000, 4'd8, 16'd10); next_cycle();
    ARESETn = 1'b0;
    drive(4'h8, 32'h0400_0000, 0, 0); check_all("rst b2", 4'd8, 1, 0, 7'd3, 16'd39999, 4'd0, 16'd10); next_cycle();
    ARESETn = 1'b1;
    drive(4'h9, 32'h0400_0000, 1, 1); check_all("rst after", 4'd0, 0, 0, 7'd0, 16'd0, 4'd0, 16'd0); next_cycle();
    drive(4'h8, 32'h0400_0000, 1, 0); check_all("rst g0", 4'd1, 1, 1, 7'd0, 16'd10000, 4'd1, 16'd0); next_cycle();
    drive(4'h8, 32'h0400_0000, 1, 0); check_all("rst idle1", 4'd0, 0, 0, 7'd0, 16'd0, 4'd0, 16'd1); next_cycle();
    drive(4'h0, 32'h0400_0000, 1, 0); check_all("rst g3b1", 4'd8, 1, 0, 7'd3, 16'd40000, 4'd8, 16'd1); next_cycle();
    drive(4'h0, 32'h0400_0000, 1, 0); check_all("rst g3b2", 4'd8, 1, 0, 7'd3, 16'd39999, 4'd8, 16'd1); next_cycle();
    drive(4'h0, 32'h0400_0000, 1, 0); check_all("rst g3b3", 4'd8, 1, 0, 7'd3, 16'd39998, 4'd8, 16'd1); next_cycle();
    drive(4'h0, 32'h0400_0000, 1, 0); check_all("rst g3b4", 4'd8, 1, 1, 7'd3, 16'd39997, 4'd8, 16'd1); next_cycle();
    drive(4'h0, 32'h0400_0000, 1, 0); check_all("rst idle2", 4'd0, 0, 0, 7'd0, 16'd0, 4'd0, 16'd2); next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_tx_arbiter.md
# axis_tx_arbiter

Round-robin arbiter and packet sequencer that shares the single AXI-Stream transmit path of the SHA3 core between up to `NUM_REQ` digest/result producers. It grants one requester at a time and streams that requester's packet as `DATA_W`-bit beats with correct `TLAST`/`TID`/`TKEEP`. Packets are atomic: a packet is never preempted. The block sits between the hash engines and the downstream AXI-Stream sink.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `DATA_W`, 16, beat width; multiple of 8
- `LEN_W`, 8, width of per-requester beat count
- `ID_W`, 7, `TID` width

- `ACLK`  in  1  clock, all logic on rising edge
- `ARESETn`  in  1  reset, synchronous, active-low
- `req_i`  in  NUM_REQ  requester i has a packet pending
- `len_i`  in  NUM_REQ*LEN_W  packet beat count of requester i; sampled at grant; 0 means 1 beat
- `data_i`  in  NUM_REQ*DATA_W  current beat of requester i; changes only after its `pop_o`
- `gnt_o`  out  NUM_REQ  one-hot grant, held for the whole packet
- `pop_o`  out  NUM_REQ  one-hot; high for the cycle requester's beat is accepted downstream
- `TVALID`  out  1  beat valid
- `TREADY`  in  1  downstream ready
- `TDATA`  out  DATA_W  `data_i` slice of the granted requester
- `TLAST`  out  1  final beat of packet
- `TID`  out  ID_W  granted requester index, zero-extended
- `TKEEP`, `TSTRB`  out  DATA_W/8 each  all ones while `TVALID`, else 0
- `busy_o`  out  1  high in SEND
- `pkt_cnt_o`  out  16  completed packets, wraps 0xFFFF→0

## Operation
- States: IDLE, SEND.
- IDLE:
  - If any `req_i` bit is set, choose the first set bit searching upward from `rr_ptr`, wrapping modulo `NUM_REQ`.
  - Register the choice into `gnt_o` and `TID`.
  - Load `beats_left` = `len_i[sel]`, or 1 if that value is 0.
  - Go to SEND.
  - With no request, stay in IDLE; all outputs stay 0.
- SEND:
  - `TVALID`=1; `TLAST` = (`beats_left`==1).
  - On `TVALID && TREADY`: `pop_o[gnt]`=1 and `beats_left` decrements.
  - On the last-beat handshake:
    - `pkt_cnt_o` increments.
    - `rr_ptr` ← granted index + 1 (mod `NUM_REQ`).
    - `gnt_o` clears and the state returns to IDLE.
- Non-preemption:
  - `req_i` changes during SEND are ignored, including deassertion by the granted requester.
  - A new request is considered only in IDLE.
- Reset:
  - `rr_ptr`=0, so requester 0 has first priority.
  - `beats_left`=0; state IDLE.
  - Outputs: `gnt_o`=0, `pop_o`=0, `TVALID`=0, `TLAST`=0, `TID`=0, `TKEEP`=0, `TSTRB`=0, `TDATA`=0, `busy_o`=0, `pkt_cnt_o`=0.
  - Reset mid-packet abandons the packet. Nothing resumes after release; the requester must re-request.

## Timing
- Grant latency: `req_i` seen high in cycle N (IDLE) → `gnt_o`, `TVALID`, `TID` high in cycle N+1.
- `gnt_o`, `TVALID`, `TLAST`, `TID`, `busy_o` and `pkt_cnt_o` are registered.
- `TDATA`, `TKEEP`, `TSTRB` and `pop_o` are combinational from registered state plus `data_i`/`TREADY`.
- Throughput: one beat per cycle while `TREADY`=1. There is exactly one idle cycle (IDLE) between consecutive packets.
- Backpressure: with `TREADY`=0, `TVALID`, `TLAST` and `TID` hold; `TDATA` holds because the requester sees no pop; `pop_o`=0.
- `TREADY` is never used to gate `TVALID` assertion (AXI rule).
- `pkt_cnt_o` updates the cycle after the last handshake, together with `TVALID` falling.

## Test plan
- **Single requester, no backpressure:**
  - Stimulus: `req_i`=0001, `len_i[0]`=3, `TREADY`=1, data 10000/9999/9998 advanced on each pop.
  - Response: `gnt_o`=0001 at N+1; three beats 10000, 9999, 9998; `TLAST` only on 9998; `TID`=0; `pkt_cnt_o`=1; IDLE again after the last beat.
- **Backpressure:**
  - Stimulus: same packet, `TREADY` low for 2 cycles while beat 9999 is presented.
  - Response: `TVALID`=1 and `TDATA`=9999 held for both cycles; `pop_o`=0 during the stall; 3 beats total; `TLAST` on 9998.
- **Round robin:**
  - Stimulus: `req_i`=1111 held, all `len_i`=1.
  - Response: `TID` sequence 0,1,2,3,0; each packet is 1 beat with `TLAST`=1; one idle cycle between packets.
- **Zero length:**
  - Stimulus: `len_i[2]`=0, `req_i`=0100.
  - Response: exactly one beat, `TLAST`=1, `TID`=2, `pkt_cnt_o`+1.
- **Non-preemption:**
  - Stimulus: req0 packet of length 4 in flight; `req_i[1]` rises on beat 2.
  - Response: all 4 beats of req0 complete first; req1 is granted in the cycle after the post-packet IDLE cycle.
- **Reset mid-packet:**
  - Stimulus: `ARESETn`=0 for one cycle during beat 2 of a 4-beat req3 packet.
  - Response: next cycle all outputs are 0 and `pkt_cnt_o`=0. After release, with `req_i`=1001, req0 is granted first, then req3 with its full length.
